// File: rtl/mips_store_buffer.sv
// Posted-write store buffer between the MIPS MEM stage and a slow req/ack data memory.
// Stores queue in a FIFO and retire in the background; non-conflicting loads bypass them.
module mips_store_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iCpuRead,
    input  logic        iCpuWrite,
    input  logic [31:0] iCpuAddress,
    input  logic [31:0] iCpuWriteData,
    input  logic [3:0]  iCpuByteEnable,
    output logic [31:0] oCpuReadData,
    output logic        oCpuStall,
    output logic        oEmpty,
    output logic        oMemReq,
    output logic        oMemWe,
    output logic [31:0] oMemAddress,
    output logic [31:0] oMemWriteData,
    output logic [3:0]  oMemByteEnable,
    input  logic        iMemAck,
    input  logic [31:0] iMemReadData
);

    typedef enum logic [1:0] {StIdle, StDrain, StRead, StRdone} state_e;

    localparam logic [PTR_W:0] CntFull = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0] CntOne  = (PTR_W + 1)'(1);

    logic [29:0]      fifo_addr_q [DEPTH];
    logic [31:0]      fifo_data_q [DEPTH];
    logic [3:0]       fifo_be_q   [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_nxt;
    logic [PTR_W:0]   count_q;
    state_e           state_q;

    logic        mem_req_q, mem_we_q;
    logic [31:0] mem_addr_q, mem_wdata_q, cpu_rdata_q;
    logic [3:0]  mem_be_q;

    logic        full, load_req, enq, deq, hit, miss_pend, cnt_after_nz;
    logic [29:0] nxt_addr;
    logic [31:0] nxt_data;
    logic [3:0]  nxt_be;
    logic        unused_addr_lsb;

    assign unused_addr_lsb = ^iCpuAddress[1:0];

    assign full         = (count_q == CntFull);
    assign load_req     = iCpuRead & ~iCpuWrite;
    assign enq          = iCpuWrite & ~full;
    assign deq          = (state_q == StDrain) & iMemAck;
    assign miss_pend    = load_req & ~hit & (state_q != StRdone);
    assign cnt_after_nz = (count_q > CntOne) | enq;
    assign rd_ptr_nxt   = rd_ptr_q + PTR_W'(1);

    // An entry is valid when its distance from the read pointer is below the count.
    always_comb begin
        hit = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (({1'b0, PTR_W'(i) - rd_ptr_q} < count_q) &&
                (fifo_addr_q[i] == iCpuAddress[31:2])) begin
                hit = 1'b1;
            end
        end
    end

    // With a single entry left, the next head is the store being enqueued right now.
    always_comb begin
        if (count_q == CntOne) begin
            nxt_addr = iCpuAddress[31:2];
            nxt_data = iCpuWriteData;
            nxt_be   = iCpuByteEnable;
        end else begin
            nxt_addr = fifo_addr_q[rd_ptr_nxt];
            nxt_data = fifo_data_q[rd_ptr_nxt];
            nxt_be   = fifo_be_q[rd_ptr_nxt];
        end
    end

    always_comb begin
        oCpuStall = 1'b0;
        if (iCpuWrite) begin
            oCpuStall = full;
        end else if (iCpuRead) begin
            oCpuStall = (state_q != StRdone);
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= StIdle;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            cpu_rdata_q <= '0;
        end else begin
            if (enq) begin
                fifo_addr_q[wr_ptr_q] <= iCpuAddress[31:2];
                fifo_data_q[wr_ptr_q] <= iCpuWriteData;
                fifo_be_q[wr_ptr_q]   <= iCpuByteEnable;
                wr_ptr_q              <= wr_ptr_q + PTR_W'(1);
            end
            if (deq) begin
                rd_ptr_q <= rd_ptr_nxt;
            end
            case ({enq, deq})
                2'b10:   count_q <= count_q + CntOne;
                2'b01:   count_q <= count_q - CntOne;
                default: count_q <= count_q;
            endcase

            case (state_q)
                StIdle: begin
                    if (miss_pend) begin
                        state_q    <= StRead;
                        mem_req_q  <= 1'b1;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= {iCpuAddress[31:2], 2'b00};
                        mem_be_q   <= 4'hF;
                    end else if (count_q != '0) begin
                        state_q     <= StDrain;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= {fifo_addr_q[rd_ptr_q], 2'b00};
                        mem_wdata_q <= fifo_data_q[rd_ptr_q];
                        mem_be_q    <= fifo_be_q[rd_ptr_q];
                    end
                end
                StDrain: begin
                    if (iMemAck) begin
                        if (miss_pend) begin
                            state_q    <= StRead;
                            mem_we_q   <= 1'b0;
                            mem_addr_q <= {iCpuAddress[31:2], 2'b00};
                            mem_be_q   <= 4'hF;
                        end else if (cnt_after_nz) begin
                            mem_addr_q  <= {nxt_addr, 2'b00};
                            mem_wdata_q <= nxt_data;
                            mem_be_q    <= nxt_be;
                        end else begin
                            state_q   <= StIdle;
                            mem_req_q <= 1'b0;
                        end
                    end
                end
                StRead: begin
                    if (iMemAck) begin
                        cpu_rdata_q <= iMemReadData;
                        mem_req_q   <= 1'b0;
                        state_q     <= StRdone;
                    end
                end
                StRdone: state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign oEmpty         = (count_q == '0) && ((state_q == StIdle) || (state_q == StRdone));
    assign oMemReq        = mem_req_q;
    assign oMemWe         = mem_we_q;
    assign oMemAddress    = mem_addr_q;
    assign oMemWriteData  = mem_wdata_q;
    assign oMemByteEnable = mem_be_q;
    assign oCpuReadData   = cpu_rdata_q;

endmodule
